depth_sweep_ctrl: RTL and testbench

Sequential front-end that streams gate feature tuples (fan-in, fan-out, gate type) into `logic_depth_predictor` one gate at a time. It captures each predicted depth and emits it as a handshaked per-gate result stream. Over a run of `gate_count` gates it accumulates a maximum depth and a depth sum. It sits between the netlist feature source and the downstream report logic, and is the driving end of the predictor's `fan_in`/`fan_out`/`gate_type` → `depth_out` interface.

---
 rtl/depth_sweep_ctrl.sv | 118 +++++++++++
 tb/tb_depth_sweep_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/depth_sweep_ctrl.sv
// depth_sweep_ctrl: streams gate feature tuples into a combinational depth
// predictor one gate at a time. It returns each predicted depth as a
// handshaked result and accumulates the run maximum and run sum.
module depth_sweep_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   gate_count,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_fan_in,
  input  logic [3:0]         in_fan_out,
  input  logic [1:0]         in_gate_type,
  output logic [3:0]         pred_fan_in,
  output logic [3:0]         pred_fan_out,
  output logic [1:0]         pred_gate_type,
  input  logic [3:0]         pred_depth,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         out_depth,
  output logic [CNT_W-1:0]   out_index,
  output logic [3:0]         max_depth,
  output logic [CNT_W+3:0]   depth_sum,
  output logic               busy,
  output logic               done
);

  localparam int SUM_W = CNT_W + 4;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EVAL  = 3'd2;
  localparam logic [2:0] S_EMIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state;
  logic [CNT_W-1:0] count;

  // Larger of two unsigned depths.
  function automatic logic [3:0] depth_max(input logic [3:0] a, input logic [3:0] b);
    return (a > b) ? a : b;
  endfunction

  // Accumulate one depth into the run sum. The width is sized so that the
  // largest possible run cannot overflow.
  function automatic logic [SUM_W-1:0] depth_acc(input logic [SUM_W-1:0] acc,
                                                 input logic [3:0]       d);
    return acc + SUM_W'(d);
  endfunction

  // Handshake and status flags are decoded from the state alone.
  assign in_ready  = (state == S_FETCH);
  assign out_valid = (state == S_EMIT);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  // Sequencer: drives the predictor, captures each result and maintains the run totals.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      count          <= '0;
      out_index      <= '0;
      pred_fan_in    <= '0;
      pred_fan_out   <= '0;
      pred_gate_type <= '0;
      out_depth      <= '0;
      max_depth      <= '0;
      depth_sum      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            count     <= gate_count;
            out_index <= '0;
            max_depth <= '0;
            depth_sum <= '0;
            state     <= (gate_count == '0) ? S_DONE : S_FETCH;
          end
        end
        // fetch -> eval: present the accepted tuple to the predictor
        S_FETCH: begin
          if (in_valid) begin
            pred_fan_in    <= in_fan_in;
            pred_fan_out   <= in_fan_out;
            pred_gate_type <= in_gate_type;
            state          <= S_EVAL;
          end
        end
        // eval -> emit: predictor output has settled for a full cycle
        S_EVAL: begin
          out_depth <= pred_depth;
          max_depth <= depth_max(max_depth, pred_depth);
          depth_sum <= depth_acc(depth_sum, pred_depth);
          state     <= S_EMIT;
        end
        S_EMIT: begin
          if (out_ready) begin
            if (out_index == count - CNT_W'(1)) begin
              state <= S_DONE;
            end else begin
              out_index <= out_index + CNT_W'(1);
              state     <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_depth_sweep_ctrl.sv
// Directed testbench for depth_sweep_ctrl. The predictor is modelled as
// depth = fan_in.
module tb_depth_sweep_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  gate_count;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_fan_in;
  logic [3:0]  in_fan_out;
  logic [1:0]  in_gate_type;
  logic [3:0]  pred_fan_in;
  logic [3:0]  pred_fan_out;
  logic [1:0]  pred_gate_type;
  logic [3:0]  pred_depth;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_depth;
  logic [7:0]  out_index;
  logic [3:0]  max_depth;
  logic [11:0] depth_sum;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [3:0]  fi;
    logic [3:0]  fo;
    logic [1:0]  gt;
    logic [3:0]  exp_depth;
    logic [7:0]  exp_index;
    logic [3:0]  exp_max;
    logic [11:0] exp_sum;
  } vec_t;

  vec_t tbl [3];

  depth_sweep_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .gate_count(gate_count),
    .in_valid(in_valid), .in_ready(in_ready), .in_fan_in(in_fan_in),
    .in_fan_out(in_fan_out), .in_gate_type(in_gate_type),
    .pred_fan_in(pred_fan_in), .pred_fan_out(pred_fan_out),
    .pred_gate_type(pred_gate_type), .pred_depth(pred_depth),
    .out_valid(out_valid), .out_ready(out_ready), .out_depth(out_depth),
    .out_index(out_index), .max_depth(max_depth), .depth_sum(depth_sum),
    .busy(busy), .done(done)
  );

  // Predictor model
  assign pred_depth = pred_fan_in;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
    chk({tag, "_pred_fan_in"}, 32'(pred_fan_in), 0);
    chk({tag, "_pred_fan_out"}, 32'(pred_fan_out), 0);
    chk({tag, "_pred_gate_type"}, 32'(pred_gate_type), 0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_out_depth"}, 32'(out_depth), 0);
    chk({tag, "_out_index"}, 32'(out_index), 0);
    chk({tag, "_max_depth"}, 32'(max_depth), 0);
    chk({tag, "_depth_sum"}, 32'(depth_sum), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
  endtask

  // One complete run of n gates (n > 0). big selects the all-fan_in=15 pattern;
  // ostall_gate / istall_gate select a gate for output or input stalls (-1 = none).
  task automatic run(input int n, input bit big, input int ostall_gate,
                     input int istall_gate, input bit spurious);
    logic [3:0]  fi, fo, em, pfi, pfo;
    logic [1:0]  gt, pgt;
    logic [3:0]  emax;
    logic [11:0] esum;
    int first_acc;
    pfi = 0; pfo = 0; pgt = 0; first_acc = 0;
    start = 1'b1;
    gate_count = n[7:0];
    tick();
    start = 1'b0;
    chk("start_in_ready", 32'(in_ready), 1);
    chk("start_busy", 32'(busy), 1);
    chk("start_max_clear", 32'(max_depth), 0);
    chk("start_sum_clear", 32'(depth_sum), 0);
    for (int i = 0; i < n; i++) begin
      if (big) begin
        fi = 4'd15; fo = i[3:0]; gt = i[1:0];
        em = 4'd15; emax = 4'd15; esum = 12'(15 * (i + 1));
      end else begin
        fi = tbl[i].fi; fo = tbl[i].fo; gt = tbl[i].gt;
        em = tbl[i].exp_depth; emax = tbl[i].exp_max; esum = tbl[i].exp_sum;
      end
      if (i == istall_gate) begin
        in_valid = 1'b0;
        in_fan_in = 4'hA; in_fan_out = 4'hB; in_gate_type = 2'd3;
        repeat (5) begin
          tick();
          chk("istall_in_ready", 32'(in_ready), 1);
          chk("istall_pred_fan_in", 32'(pred_fan_in), 32'(pfi));
          chk("istall_pred_fan_out", 32'(pred_fan_out), 32'(pfo));
          chk("istall_pred_gate_type", 32'(pred_gate_type), 32'(pgt));
        end
      end
      in_valid = 1'b1;
      in_fan_in = fi; in_fan_out = fo; in_gate_type = gt;
      if (i == 0) first_acc = cyc;
      tick();
      in_valid = 1'b0;
      in_fan_in = ~fi; in_fan_out = ~fo; in_gate_type = ~gt;
      chk("eval_pred_fan_in", 32'(pred_fan_in), 32'(fi));
      chk("eval_pred_fan_out", 32'(pred_fan_out), 32'(fo));
      chk("eval_pred_gate_type", 32'(pred_gate_type), 32'(gt));
      chk("eval_out_valid", 32'(out_valid), 0);
      chk("eval_in_ready", 32'(in_ready), 0);
      if (spurious && i == 1) begin
        start = 1'b1;
        gate_count = 8'd9;
      end
      tick();
      start = 1'b0;
      gate_count = n[7:0];
      chk("emit_out_valid", 32'(out_valid), 1);
      chk("emit_out_depth", 32'(out_depth), 32'(em));
      chk("emit_out_index", 32'(out_index), i);
      chk("emit_max_depth", 32'(max_depth), 32'(emax));
      chk("emit_depth_sum", 32'(depth_sum), 32'(esum));
      chk("emit_pred_stable", 32'(pred_fan_in), 32'(fi));
      chk("emit_done_low", 32'(done), 0);
      if (i == ostall_gate) begin
        out_ready = 1'b0;
        repeat (4) begin
          tick();
          chk("ostall_out_valid", 32'(out_valid), 1);
          chk("ostall_out_depth", 32'(out_depth), 32'(em));
          chk("ostall_out_index", 32'(out_index), i);
          chk("ostall_in_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
      end
      tick();
      pfi = fi; pfo = fo; pgt = gt;
    end
    chk("end_done", 32'(done), 1);
    chk("end_max_depth", 32'(max_depth), big ? 32'd15 : 32'd12);
    chk("end_depth_sum", 32'(depth_sum), big ? 32'd3825 : 32'd24);
    chk("end_out_valid", 32'(out_valid), 0);
    if (!big && ostall_gate < 0 && istall_gate < 0)
      chk("accept_to_done_cycles", cyc - first_acc, 9);
    tick();
    chk("post_done_low", 32'(done), 0);
    chk("post_busy_low", 32'(busy), 0);
    chk("post_max_hold", 32'(max_depth), big ? 32'd15 : 32'd12);
    chk("post_sum_hold", 32'(depth_sum), big ? 32'd3825 : 32'd24);
  endtask

  initial begin
    tbl[0] = '{fi: 4'd5,  fo: 4'd3, gt: 2'd1, exp_depth: 4'd5,  exp_index: 8'd0, exp_max: 4'd5,  exp_sum: 12'd5};
    tbl[1] = '{fi: 4'd12, fo: 4'd2, gt: 2'd0, exp_depth: 4'd12, exp_index: 8'd1, exp_max: 4'd12, exp_sum: 12'd17};
    tbl[2] = '{fi: 4'd7,  fo: 4'd9, gt: 2'd3, exp_depth: 4'd7,  exp_index: 8'd2, exp_max: 4'd12, exp_sum: 12'd24};

    rst = 1'b1; start = 1'b0; gate_count = 8'd0;
    in_valid = 1'b0; in_fan_in = 4'd0; in_fan_out = 4'd0; in_gate_type = 2'd0;
    out_ready = 1'b1;
    @(negedge clk);
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 0);

    // Reset mid-run: gate 1 of 3 sitting in EMIT
    start = 1'b1; gate_count = 8'd3;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_fan_in = 4'd5; in_fan_out = 4'd3; in_gate_type = 2'd1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    in_valid = 1'b1; in_fan_in = 4'd12; in_fan_out = 4'd2; in_gate_type = 2'd0;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    chk("rstmid_in_emit", 32'(out_valid), 1);
    chk("rstmid_index", 32'(out_index), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    chk_all_zero("rstmid");
    repeat (3) begin
      tick();
      chk("rstmid_no_done", 32'(done), 0);
      chk("rstmid_stay_idle", 32'(busy), 0);
    end

    // Basic run
    run(3, 1'b0, -1, -1, 1'b0);
    // Output backpressure on gate 1
    run(3, 1'b0, 1, -1, 1'b0);
    // Input stall before gate 2
    run(3, 1'b0, -1, 2, 1'b0);
    // Spurious start mid-run
    run(3, 1'b0, -1, -1, 1'b1);
    tick();
    chk("spurious_no_restart", 32'(busy), 0);

    // Zero-gate run: totals from the previous run must clear
    start = 1'b1; gate_count = 8'd0;
    tick();
    start = 1'b0;
    chk("zero_done", 32'(done), 1);
    chk("zero_busy", 32'(busy), 1);
    chk("zero_in_ready", 32'(in_ready), 0);
    chk("zero_max", 32'(max_depth), 0);
    chk("zero_sum", 32'(depth_sum), 0);
    tick();
    chk("zero_done_low", 32'(done), 0);
    chk("zero_busy_low", 32'(busy), 0);

    // Maximum-length run
    run(255, 1'b1, -1, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
